mash_pipe_acc: RTL and testbench

//  Pipelined first-order accumulator stage of the MASH DDSM. It sits directly

---
 rtl/mash_pipe_acc_pkg.sv | 19 +
 rtl/mash_pipe_acc_if.sv | 24 ++
 rtl/mash_acc_slice.sv | 58 +++++
 rtl/mash_pipe_acc.sv | 88 ++++++++
 tb/tb_mash_pipe_acc.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mash_pipe_acc_pkg.sv
// rtl/mash_pipe_acc_pkg.sv - shared MASH stage constants and LFSR helper
package mash_pipe_acc_pkg;

  localparam int MASH_SLICE_W    = 8;
  localparam int MASH_SLICE_SKEW = 2;
  localparam int MASH_NUM_SLICES = 3;

  // x^15 + x^14 + 1 Fibonacci LFSR: taps on state bits 14 and 13
  localparam int          MASH_LFSR_W    = 15;
  localparam logic [14:0] MASH_LFSR_SEED = 15'h0001;
  localparam logic [14:0] MASH_LFSR_TAPS = 15'h6000;

  typedef logic [MASH_SLICE_W-1:0] slice_t;

  function automatic logic [14:0] lfsr_next(input logic [14:0] s);
    return {s[13:0], ^(s & MASH_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mash_pipe_acc_if.sv
// rtl/mash_pipe_acc_if.sv - skewed slice bus between MASH accumulator stages
interface mash_pipe_acc_if #(
  parameter int P_SLICE_W = 8
);
  logic                 en;
  logic                 clr;
  logic [P_SLICE_W-1:0] lsb;
  logic [P_SLICE_W-1:0] isb;
  logic [P_SLICE_W-1:0] msb;
  logic [P_SLICE_W-1:0] lsb_res;
  logic [P_SLICE_W-1:0] isb_res;
  logic [P_SLICE_W-1:0] msb_res;
  logic                 carry;

  modport master (
    output en, clr, lsb, isb, msb,
    input  lsb_res, isb_res, msb_res, carry
  );

  modport slave (
    input  en, clr, lsb, isb, msb,
    output lsb_res, isb_res, msb_res, carry
  );
endinterface

// File: rtl/mash_acc_slice.sv
// rtl/mash_acc_slice.sv - one accumulator slice with registered carry and delay pipe
module mash_acc_slice #(
  parameter int P_W          = 8,
  parameter int P_PIPE_DEPTH = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           clr,
  input  logic [P_W-1:0] din,
  input  logic           cin,
  output logic [P_W-1:0] acc,
  output logic           carry_d
);

  logic [P_W:0] sum;
  logic         carry_q;

  assign sum = {1'b0, acc} + {1'b0, din} + {{P_W{1'b0}}, cin};

  // Accumulate modulo 2^P_W; the add's top bit becomes the registered carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {carry_q, acc} <= '0;
    end else if (clr) begin
      {carry_q, acc} <= '0;
    end else if (en) begin
      {carry_q, acc} <= sum;
    end
  end

  // The carry register already supplies one cycle of delay, so the pipe adds
  // the remaining cycles needed to meet the next slice's skewed input.
  generate
    if (P_PIPE_DEPTH == 0) begin : g_no_pipe
      assign carry_d = carry_q;
    end else begin : g_pipe
      logic [P_PIPE_DEPTH-1:0] pipe;

      // Shift the carry toward the next slice, frozen by en
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe <= '0;
        end else if (clr) begin
          pipe <= '0;
        end else if (en) begin
          pipe[0] <= carry_q;
          for (int i = 1; i < P_PIPE_DEPTH; i++) begin
            pipe[i] <= pipe[i-1];
          end
        end
      end

      assign carry_d = pipe[P_PIPE_DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mash_pipe_acc.sv
// rtl/mash_pipe_acc.sv - skewed 3-slice first-order MASH accumulator (optional MASH_ACC_DITHER_EN)
module mash_pipe_acc
  import mash_pipe_acc_pkg::*;
#(
  parameter int P_SLICE_W    = MASH_SLICE_W,
  parameter int P_SLICE_SKEW = MASH_SLICE_SKEW
) (
  input  logic            i_clk,
  input  logic            i_rst,
  mash_pipe_acc_if.slave  bus
);

  logic                 cin0;
  logic                 c0_d;
  logic                 c1_d;
  logic [P_SLICE_W-1:0] lsb_acc;
  logic [P_SLICE_W-1:0] isb_acc;
  logic [P_SLICE_W-1:0] msb_acc;
  logic                 msb_carry;

`ifdef MASH_ACC_DITHER_EN
  logic [MASH_LFSR_W-1:0] lfsr;

  // Dither source: restarts from the seed on reset/clear, steps with en
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lfsr <= MASH_LFSR_SEED;
    end else if (bus.clr) begin
      lfsr <= MASH_LFSR_SEED;
    end else if (bus.en) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign cin0 = lfsr[0];
`else
  assign cin0 = 1'b0;
`endif

  mash_acc_slice #(
    .P_W          (P_SLICE_W),
    .P_PIPE_DEPTH (P_SLICE_SKEW - 1)
  ) u_lsb (
    .clk     (i_clk),
    .rst     (i_rst),
    .en      (bus.en),
    .clr     (bus.clr),
    .din     (bus.lsb),
    .cin     (cin0),
    .acc     (lsb_acc),
    .carry_d (c0_d)
  );

  mash_acc_slice #(
    .P_W          (P_SLICE_W),
    .P_PIPE_DEPTH (P_SLICE_SKEW - 1)
  ) u_isb (
    .clk     (i_clk),
    .rst     (i_rst),
    .en      (bus.en),
    .clr     (bus.clr),
    .din     (bus.isb),
    .cin     (c0_d),
    .acc     (isb_acc),
    .carry_d (c1_d)
  );

  // The MSB carry is the stage output bit, so it leaves straight from the register
  mash_acc_slice #(
    .P_W          (P_SLICE_W),
    .P_PIPE_DEPTH (0)
  ) u_msb (
    .clk     (i_clk),
    .rst     (i_rst),
    .en      (bus.en),
    .clr     (bus.clr),
    .din     (bus.msb),
    .cin     (c1_d),
    .acc     (msb_acc),
    .carry_d (msb_carry)
  );

  assign bus.lsb_res = lsb_acc;
  assign bus.isb_res = isb_acc;
  assign bus.msb_res = msb_acc;
  assign bus.carry   = msb_carry;

endmodule

// File: tb/tb_mash_pipe_acc.sv
// tb/tb_mash_pipe_acc.sv - directed self-checking bench for mash_pipe_acc
module tb_mash_pipe_acc;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   k;
  logic [23:0] words [0:63];

  mash_pipe_acc_if bus ();

  mash_pipe_acc dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] exp_res(input logic [23:0] w, input int n);
    longint s;
    s = longint'(w) * longint'(n + 1);
    return s[23:0];
  endfunction

  function automatic logic exp_carry(input logic [23:0] w, input int n);
    longint a;
    longint b;
    a = (longint'(w) * longint'(n + 1)) >> 24;
    b = (longint'(w) * longint'(n)) >> 24;
    return a != b;
  endfunction

  task automatic fill_const(input logic [23:0] w);
    for (int i = 0; i < 64; i++) words[i] = w;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    bus.clr = 1'b0;
    bus.lsb = '0;
    bus.isb = '0;
    bus.msb = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
  endtask

  // Present cycle k's skewed slices, clock once, sample 1 time unit later
  task automatic drive_cycle(input logic en_v);
    logic [23:0] wl, wi, wm;
    wl = words[k];
    wi = (k >= 2) ? words[k-2] : 24'h0;
    wm = (k >= 4) ? words[k-4] : 24'h0;
    bus.en  = en_v;
    bus.lsb = wl[7:0];
    bus.isb = wi[15:8];
    bus.msb = wm[23:16];
    @(posedge clk);
    #1;
    if (en_v) k++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1;
    bus.clr = 1'b0;
    #1;
    checks++; if (bus.lsb_res !== 8'h00) begin failures++; $display("FAIL reset_lsb actual=%h required=00", bus.lsb_res); end
    checks++; if (bus.isb_res !== 8'h00) begin failures++; $display("FAIL reset_isb actual=%h required=00", bus.isb_res); end
    checks++; if (bus.msb_res !== 8'h00) begin failures++; $display("FAIL reset_msb actual=%h required=00", bus.msb_res); end
    checks++; if (bus.carry !== 1'b0) begin failures++; $display("FAIL reset_carry actual=%b required=0", bus.carry); end
  endtask

  task automatic test_half_scale();
    logic [7:0] em;
    logic       ec;
    int         n;
    apply_reset();
    fill_const(24'h800000);
    for (int c = 0; c < 14; c++) begin
      drive_cycle(1'b1);
      n  = c - 4;
      ec = (n >= 0) && (n % 2 == 1);
      em = (n >= 0 && n % 2 == 0) ? 8'h80 : 8'h00;
      checks++; if (bus.carry !== ec) begin failures++; $display("FAIL half_carry cyc=%0d actual=%b required=%b", c, bus.carry, ec); end
      checks++; if (bus.msb_res !== em) begin failures++; $display("FAIL half_msb cyc=%0d actual=%h required=%h", c, bus.msb_res, em); end
    end
  endtask

  task automatic test_quarter_scale();
    logic [7:0] em;
    logic       ec;
    int         n;
    apply_reset();
    fill_const(24'h400000);
    for (int c = 0; c < 16; c++) begin
      drive_cycle(1'b1);
      n  = c - 4;
      ec = (n >= 0) && (n % 4 == 3);
      em = (n >= 0) ? 8'((((n + 1) % 4) * 64)) : 8'h00;
      checks++; if (bus.carry !== ec) begin failures++; $display("FAIL quarter_carry cyc=%0d actual=%b required=%b", c, bus.carry, ec); end
      checks++; if (bus.msb_res !== em) begin failures++; $display("FAIL quarter_msb cyc=%0d actual=%h required=%h", c, bus.msb_res, em); end
    end
  endtask

  task automatic test_ripple();
    logic [23:0] er [0:11];
    logic        ecar [0:11];
    logic [23:0] t;
    for (int i = 0; i < 64; i++) words[i] = (i < 3) ? 24'h7FFFFF : 24'h000000;
    for (int i = 0; i < 12; i++) begin
      er[i]   = (i == 0) ? 24'h7FFFFF : (i == 1) ? 24'hFFFFFE : 24'h7FFFFD;
      ecar[i] = (i == 2);
    end
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      drive_cycle(1'b1);
      t = er[c];
      checks++; if (bus.lsb_res !== t[7:0]) begin failures++; $display("FAIL ripple_lsb cyc=%0d actual=%h required=%h", c, bus.lsb_res, t[7:0]); end
      if (c >= 2) begin
        t = er[c-2];
        checks++; if (bus.isb_res !== t[15:8]) begin failures++; $display("FAIL ripple_isb cyc=%0d actual=%h required=%h", c, bus.isb_res, t[15:8]); end
      end
      if (c >= 4) begin
        t = er[c-4];
        checks++; if (bus.msb_res !== t[23:16]) begin failures++; $display("FAIL ripple_msb cyc=%0d actual=%h required=%h", c, bus.msb_res, t[23:16]); end
        checks++; if (bus.carry !== ecar[c-4]) begin failures++; $display("FAIL ripple_carry cyc=%0d actual=%b required=%b", c, bus.carry, ecar[c-4]); end
      end
    end
  endtask

  task automatic test_stall();
    logic [23:0] w;
    logic [23:0] rl, ri, rm;
    logic        ec;
    w = 24'h400000;
    apply_reset();
    fill_const(w);
    for (int c = 0; c < 10; c++) drive_cycle(1'b1);
    rl = exp_res(w, 9);
    ri = exp_res(w, 7);
    rm = exp_res(w, 5);
    ec = exp_carry(w, 5);
    for (int s = 0; s < 7; s++) begin
      drive_cycle(1'b0);
      checks++; if (bus.lsb_res !== rl[7:0]) begin failures++; $display("FAIL stall_lsb cyc=%0d actual=%h required=%h", s, bus.lsb_res, rl[7:0]); end
      checks++; if (bus.isb_res !== ri[15:8]) begin failures++; $display("FAIL stall_isb cyc=%0d actual=%h required=%h", s, bus.isb_res, ri[15:8]); end
      checks++; if (bus.msb_res !== rm[23:16]) begin failures++; $display("FAIL stall_msb cyc=%0d actual=%h required=%h", s, bus.msb_res, rm[23:16]); end
      checks++; if (bus.carry !== ec) begin failures++; $display("FAIL stall_carry cyc=%0d actual=%b required=%b", s, bus.carry, ec); end
    end
    for (int c = 10; c < 20; c++) begin
      drive_cycle(1'b1);
      rm = exp_res(w, c - 4);
      ec = exp_carry(w, c - 4);
      checks++; if (bus.carry !== ec) begin failures++; $display("FAIL resume_carry cyc=%0d actual=%b required=%b", c, bus.carry, ec); end
      checks++; if (bus.msb_res !== rm[23:16]) begin failures++; $display("FAIL resume_msb cyc=%0d actual=%h required=%h", c, bus.msb_res, rm[23:16]); end
    end
  endtask

  task automatic test_async_reset();
    logic ec;
    int   n;
    apply_reset();
    fill_const(24'h800000);
    bus.clr = 1'b0;
    for (int c = 0; c < 7; c++) drive_cycle(1'b1);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.lsb_res !== 8'h00) begin failures++; $display("FAIL areset_lsb actual=%h required=00", bus.lsb_res); end
    checks++; if (bus.msb_res !== 8'h00) begin failures++; $display("FAIL areset_msb actual=%h required=00", bus.msb_res); end
    checks++; if (bus.carry !== 1'b0) begin failures++; $display("FAIL areset_carry actual=%b required=0", bus.carry); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      drive_cycle(1'b1);
      n  = c - 4;
      ec = (n >= 0) && (n % 2 == 1);
      checks++; if (bus.carry !== ec) begin failures++; $display("FAIL restart_carry cyc=%0d actual=%b required=%b", c, bus.carry, ec); end
    end
  endtask

  task automatic test_all_ones_and_clear();
    logic [23:0] w;
    logic        ec;
    w = 24'hFFFFFF;
    apply_reset();
    fill_const(w);
    for (int c = 0; c < 9; c++) begin
      drive_cycle(1'b1);
      ec = (c >= 4) && (c - 4 >= 1);
      checks++; if (bus.carry !== ec) begin failures++; $display("FAIL ones_carry cyc=%0d actual=%b required=%b", c, bus.carry, ec); end
    end
    bus.clr = 1'b1;
    drive_cycle(1'b0);
    bus.clr = 1'b0;
    checks++; if (bus.lsb_res !== 8'h00) begin failures++; $display("FAIL clr_lsb actual=%h required=00", bus.lsb_res); end
    checks++; if (bus.isb_res !== 8'h00) begin failures++; $display("FAIL clr_isb actual=%h required=00", bus.isb_res); end
    checks++; if (bus.msb_res !== 8'h00) begin failures++; $display("FAIL clr_msb actual=%h required=00", bus.msb_res); end
    checks++; if (bus.carry !== 1'b0) begin failures++; $display("FAIL clr_carry actual=%b required=0", bus.carry); end
    k = 0;
    for (int c = 0; c < 8; c++) begin
      drive_cycle(1'b1);
      ec = (c >= 5);
      checks++; if (bus.carry !== ec) begin failures++; $display("FAIL post_clr_carry cyc=%0d actual=%b required=%b", c, bus.carry, ec); end
    end
  endtask

  task automatic test_zero();
    apply_reset();
    fill_const(24'h000000);
    for (int c = 0; c < 8; c++) begin
      drive_cycle(1'b1);
      checks++;
      if ({bus.lsb_res, bus.isb_res, bus.msb_res, bus.carry} !== 25'h0) begin
        failures++;
        $display("FAIL zero_out cyc=%0d actual=%h required=0", c, {bus.lsb_res, bus.isb_res, bus.msb_res, bus.carry});
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    failures = 0;
    k = 0;
    bus.en = 1'b0;
    bus.clr = 1'b0;
    bus.lsb = '0;
    bus.isb = '0;
    bus.msb = '0;
    fill_const(24'h0);
    test_reset();
    test_half_scale();
    test_quarter_scale();
    test_ripple();
    test_stall();
    test_async_reset();
    test_all_ones_and_clear();
    test_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
